// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit format, port codes, FSM states and XY route helper
package noc_pkg;

  localparam int FLIT_W    = 32;
  localparam int COORD_W   = 4;
  localparam int PORT_N    = 5;
  localparam int PORT_W    = 3;
  localparam int TYPE_LSB  = FLIT_W - 2;
  localparam int DST_X_LSB = 0;
  localparam int DST_Y_LSB = COORD_W;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_type_e;

  localparam logic [PORT_W-1:0] LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] EAST  = 3'd1;
  localparam logic [PORT_W-1:0] WEST  = 3'd2;
  localparam logic [PORT_W-1:0] NORTH = 3'd3;
  localparam logic [PORT_W-1:0] SOUTH = 3'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] f);
    return flit_type_e'(f[TYPE_LSB +: 2]);
  endfunction

  // X is resolved before Y so packets never turn back into the X dimension.
  function automatic logic [PORT_W-1:0] xy_route(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] my_x,
    input logic [COORD_W-1:0] my_y
  );
    if (dst_x > my_x)      return EAST;
    else if (dst_x < my_x) return WEST;
    else if (dst_y > my_y) return NORTH;
    else if (dst_y < my_y) return SOUTH;
    else                   return LOCAL;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - flit buffer with wrapping pointers and an occupancy count
module flit_fifo #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [FLIT_W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so flit_o reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/noc_inport.sv
// rtl/noc_inport.sv - router input port: flit buffer, XY route and wormhole request hold
module noc_inport
  import noc_pkg::*;
#(
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] flit_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              req_o,
  output logic [PORT_W-1:0] port_o,
  input  logic              grt_i,
  output logic [FLIT_W-1:0] flit_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              err_o
);

  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

  state_e            state_q, state_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic              full, empty, push, pop;
  logic [FLIT_W-1:0] head;
  flit_type_e        head_type;

  assign ready_o   = ~full;
  assign push      = valid_i & ready_o;
  assign head_type = flit_type(head);
  assign flit_o    = head;
  assign req_o     = (state_q == ACTIVE);
  assign port_o    = port_q;

  flit_fifo #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (flit_i),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    pop     = 1'b0;
    err_o   = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_type == HEAD || head_type == HEADTAIL) begin
            port_d  = xy_route(head[DST_X_LSB +: COORD_W], head[DST_Y_LSB +: COORD_W],
                               MY_X_C, MY_Y_C);
            state_d = ACTIVE;
          end else begin
            // Orphan body/tail with no open packet: discard it so the port cannot wedge.
            pop   = 1'b1;
            err_o = 1'b1;
          end
        end
      end
      ACTIVE: begin
        valid_o = ~empty;
        if (valid_o && grt_i && ready_i) begin
          pop = 1'b1;
          if (head_type == TAIL || head_type == HEADTAIL) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      port_q  <= LOCAL;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

endmodule

// File: tb/tb_noc_inport.sv
// tb/tb_noc_inport.sv - randomized and directed checks of noc_inport against a queue model
module tb_noc_inport;
  import noc_pkg::*;

  localparam int TMX = 1;
  localparam int TMY = 1;
  localparam int TDEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [FLIT_W-1:0] flit_i = '0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic              req_o;
  logic [PORT_W-1:0] port_o;
  logic              grt_i = 1'b0;
  logic [FLIT_W-1:0] flit_o;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic              err_o;

  noc_inport #(.MY_X(TMX), .MY_Y(TMY), .DEPTH(TDEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flit_i  (flit_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .req_o   (req_o),
    .port_o  (port_o),
    .grt_i   (grt_i),
    .flit_o  (flit_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mq[$];
  logic [31:0] got[$];
  bit          m_active = 0;
  int          m_port = 0;

  function automatic logic [31:0] mk(int t, int dx, int dy, int pay);
    logic [31:0] f;
    f = '0;
    f[31:30] = t[1:0];
    f[29:8]  = pay[21:0];
    f[7:4]   = dy[3:0];
    f[3:0]   = dx[3:0];
    return f;
  endfunction

  function automatic int route_ref(logic [31:0] f);
    int dx, dy;
    dx = int'(f[3:0]);
    dy = int'(f[7:4]);
    if (dx > TMX) return 1;
    if (dx < TMX) return 2;
    if (dy > TMY) return 3;
    if (dy < TMY) return 4;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT against the model, advance the model across the edge.
  task automatic step();
    bit exp_ready, exp_valid, exp_err, mpop, mpush, n_active;
    int n_port, t0;
    logic [31:0] in_flit;
    exp_ready = (mq.size() < TDEPTH);
    exp_valid = m_active && mq.size() > 0;
    t0 = (mq.size() > 0) ? int'(mq[0][31:30]) : 0;
    exp_err = !m_active && mq.size() > 0 && (t0 == 1 || t0 == 2);
    chk("ready_o", 32'(ready_o), 32'(exp_ready));
    chk("req_o", 32'(req_o), 32'(m_active));
    chk("port_o", 32'(port_o), 32'(m_port));
    chk("valid_o", 32'(valid_o), 32'(exp_valid));
    chk("err_o", 32'(err_o), 32'(exp_err));
    if (exp_valid) chk("flit_o", flit_o, mq[0]);
    if (valid_o && grt_i && ready_i) got.push_back(flit_o);
    mpop = (exp_valid && grt_i && ready_i) || exp_err;
    mpush = valid_i && exp_ready;
    in_flit = flit_i;
    n_active = m_active;
    n_port = m_port;
    if (!m_active && mq.size() > 0 && !exp_err) begin
      n_active = 1;
      n_port = route_ref(mq[0]);
    end
    if (exp_valid && grt_i && ready_i && (t0 == 2 || t0 == 3)) n_active = 0;
    @(posedge clk);
    if (mpop) void'(mq.pop_front());
    if (mpush) mq.push_back(in_flit);
    m_active = n_active;
    m_port = n_port;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_req"}, 32'(req_o), 32'd0);
    chk({tag, "_port"}, 32'(port_o), 32'd0);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_flit"}, flit_o, 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 0;
    m_port = 0;
  endtask

  initial begin
    logic [31:0] exp_list[4];
    int accepted;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_reset_outputs("reset");

    // HEADTAIL to (3,1) routes EAST; request appears two cycles after the push.
    grt_i = 1; ready_i = 1;
    valid_i = 1; flit_i = mk(3, 3, 1, 11);
    step();
    valid_i = 0;
    chk("t1_req_t1", 32'(req_o), 32'd0);
    step();
    chk("t1_req_t2", 32'(req_o), 32'd1);
    chk("t1_port", 32'(port_o), 32'd1);
    chk("t1_valid", 32'(valid_o), 32'd1);
    step();
    chk("t1_req_done", 32'(req_o), 32'd0);

    // HEAD to (1,0) with grant withdrawn mid-packet.
    got.delete();
    exp_list[0] = mk(0, 1, 0, 21);
    exp_list[1] = mk(1, 5, 5, 22);
    exp_list[2] = mk(1, 6, 6, 23);
    exp_list[3] = mk(2, 7, 7, 24);
    for (int k = 0; k < 4; k++) begin
      valid_i = 1; flit_i = exp_list[k];
      step();
    end
    valid_i = 0; grt_i = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_hold_req", 32'(req_o), 32'd1);
      chk("t2_hold_port", 32'(port_o), 32'd4);
      step();
    end
    grt_i = 1;
    for (int i = 0; i < 20 && req_o; i++) begin
      chk("t2_port", 32'(port_o), 32'd4);
      step();
    end
    chk("t2_req_fall", 32'(req_o), 32'd0);
    chk("t2_count", got.size(), 32'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("t2_order", got[k], exp_list[k]);

    // Fill the FIFO with downstream stalled, then drain.
    got.delete();
    ready_i = 0; grt_i = 1; accepted = 0;
    for (int k = 0; k < 6; k++) begin
      valid_i = 1;
      flit_i = (k == 0) ? mk(0, 3, 1, 30) : mk(1, 0, 0, 30 + k);
      if (k < 4) exp_list[k] = flit_i;
      if (ready_o) accepted++;
      step();
    end
    valid_i = 0;
    chk("t3_accepted", accepted, 32'd4);
    chk("t3_full", 32'(ready_o), 32'd0);
    ready_i = 1;
    for (int i = 0; i < 20 && got.size() < 4; i++) step();
    chk("t3_count", got.size(), 32'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("t3_order", got[k], exp_list[k]);
    chk("t3_ready_back", 32'(ready_o), 32'd1);
    valid_i = 1; flit_i = mk(2, 0, 0, 39);
    step();
    valid_i = 0;
    for (int i = 0; i < 20 && req_o; i++) step();
    chk("t3_closed", 32'(req_o), 32'd0);

    // Orphan BODY is dropped with a single-cycle error pulse.
    valid_i = 1; flit_i = mk(1, 2, 2, 40);
    step();
    valid_i = 0;
    chk("t4_err", 32'(err_o), 32'd1);
    chk("t4_req", 32'(req_o), 32'd0);
    step();
    chk("t4_err_off", 32'(err_o), 32'd0);
    chk("t4_req_off", 32'(req_o), 32'd0);

    // Local destination, and FIFO running dry mid-packet.
    valid_i = 1; flit_i = mk(0, 1, 1, 50);
    step();
    valid_i = 0;
    step();
    chk("t5_port", 32'(port_o), 32'd0);
    chk("t5_req", 32'(req_o), 32'd1);
    step();
    chk("t5_dry_valid", 32'(valid_o), 32'd0);
    chk("t5_dry_req", 32'(req_o), 32'd1);
    valid_i = 1; flit_i = mk(2, 0, 0, 51);
    step();
    valid_i = 0;
    step();
    chk("t5_closed", 32'(req_o), 32'd0);

    // Reset while a packet is active with three flits buffered.
    grt_i = 0;
    valid_i = 1; flit_i = mk(0, 3, 3, 60); step();
    flit_i = mk(1, 0, 0, 61); step();
    flit_i = mk(1, 0, 0, 62); step();
    valid_i = 0;
    chk("t6_active", 32'(req_o), 32'd1);
    chk("t6_depth", mq.size(), 32'd3);
    #2 rst_n = 0;
    #1 chk_reset_outputs("t6_async");
    model_reset();
    @(negedge clk);
    chk_reset_outputs("t6_held");
    rst_n = 1;
    step();
    chk("t6_empty_valid", 32'(valid_o), 32'd0);
    chk("t6_empty_req", 32'(req_o), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      valid_i = ($urandom_range(0, 9) < 7);
      flit_i = mk((r < 4) ? 0 : (r < 6) ? 3 : (r < 8) ? 1 : 2,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      grt_i = ($urandom_range(0, 9) < 8);
      ready_i = ($urandom_range(0, 9) < 8);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
